keypad_digit_latch: RTL
=======================

# keypad_digit_latch

Downstream stage of the keypad row scanner. Takes the scanner's one-cycle `enable` pulse and its `{rows, columns}` key code, then decodes the code to a hex digit. It confirms the key stays stable for a programmable debounce window and commits it into a two-digit history (newest/previous) for the dual seven-segment display path. Each physical press commits at most one digit; a new commit requires a release first.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: cycles the key code must stay stable after `enable` before commit. Legal values are 1 or greater.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  one-cycle pulse from the scanner; a candidate key is present.
- `total_val`  in  8  `{rows[3:0], columns[3:0]}`.
  - Rows are one-hot active-high; `rows[3]` is row 1.
  - Columns are active-low; `columns[3]` is column 1.
- `key_pressed`  in  1  high while any column is low.
- `digit_new`  out  4  most recently committed digit.
- `digit_old`  out  4  digit committed before `digit_new`.
- `new_digit`  out  1  one-cycle strobe; the digit registers have just updated.
- `bad_key`  out  1  one-cycle strobe; `enable` was seen with an undecodable code.

## Operation
- Key map, rows 1–4 by columns 1–4:
  - Row 1: 1 2 3 A
  - Row 2: 4 5 6 B
  - Row 3: 7 8 9 C
  - Row 4: E 0 F D
- Decode is valid only if exactly one row bit is high and exactly one column bit is low. Anything else is invalid.
- FSM states: IDLE, CHECK, COMMIT, HOLD.
  - **IDLE**
    - `enable` with a valid code: latch the code into `cand_code`, clear the counter, go to CHECK.
    - `enable` with an invalid code: assert `bad_key` next cycle, stay in IDLE.
    - No `enable`: stay in IDLE.
  - **CHECK**, evaluated every cycle:
    - If `key_pressed` is 0 or `total_val` ≠ `cand_code`: go to IDLE with no commit.
    - Else if counter = `DEBOUNCE_CYCLES`−1: go to COMMIT, with `digit_old` ← `digit_new` and `digit_new` ← decode(`cand_code`) on the same edge.
    - Else: increment the counter.
  - **COMMIT**: one cycle with `new_digit` = 1. Unconditionally go to HOLD.
  - **HOLD**: stay while `key_pressed` = 1. Go to IDLE on the first cycle `key_pressed` = 0.
- `enable` is ignored in CHECK, COMMIT and HOLD. It does not restart the counter and does not raise `bad_key`.
- Repeated presses of the same key commit each time, so "5,5" gives old=5, new=5.

## Timing
- Reset values, asynchronous:
  - state = IDLE, counter = 0, `cand_code` = 0
  - `digit_new` = 0, `digit_old` = 0
  - `new_digit` = 0, `bad_key` = 0
- Reset asserted mid-CHECK, COMMIT or HOLD: all of the above take effect immediately, and any pending digit is discarded.
- `new_digit` is a Moore output (state == COMMIT). It is high in the first cycle the updated digits are visible.
- `bad_key` is registered and high for exactly one cycle, the cycle after the offending `enable`.
- Latency: `enable` high in cycle c0 → CHECK in c1..cD (D = `DEBOUNCE_CYCLES`) → COMMIT in cD+1. `new_digit` rises D+1 cycles after the `enable` cycle.
- Minimum press-to-next-commit: D+3 cycles (a release cycle is needed in HOLD).
- Counter width is $clog2(`DEBOUNCE_CYCLES`+1); it never wraps because CHECK exits at D−1.
- If `key_pressed` falls in the same cycle as counter = D−1, the abort wins: no commit.

## Structure
- Shared package `keypad_pkg`:
  - state enum `latch_state_t`
  - the 4×4 key-map constants
  - row/column one-hot index helpers
- Sub-module `key_decoder` (combinational): `total_val[7:0]` → `{valid, digit[3:0]}`. Used for both the IDLE validity check and the COMMIT value.
- The top level holds the FSM, counter, `cand_code` register and digit history registers.

## Test plan
Test benches use `DEBOUNCE_CYCLES` = 4 unless stated.
- **Reset:** pulse `reset` low mid-clock → all outputs read 0 at once; `new_digit` stays 0.
- **Single press:** `enable` with 0x4B (key 5), key held and stable → `new_digit` in cycle c5; `digit_new` = 5, `digit_old` = 0; then HOLD until release.
- **Sequence:** presses 0x87 (key 1) then 0x1E (key D), with releases between → after the second commit, `digit_new` = D and `digit_old` = 1.
- **Bounce:** `enable` with 0x1B (key 0), `total_val` flips to 0x17 in c2 → return to IDLE; no `new_digit`; digits unchanged.
- **Invalid codes:** `enable` with 0x83 (two columns low), then with 0xC7 (two rows high) → `bad_key` pulse once each, no state change. Also issue `enable` while in HOLD → ignored, no `bad_key`.
- **Edge cases:**
  - With `DEBOUNCE_CYCLES` = 1: commit in c2.
  - Release coinciding with the final CHECK cycle → no commit.
  - Reset during HOLD → IDLE, digits cleared.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, key map and line-index helpers for the keypad digit latch.
package keypad_pkg;

    localparam int unsigned CODE_W  = 8;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned LINE_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        COMMIT = 2'd2,
        HOLD   = 2'd3
    } latch_state_t;

    // Row-major key map; element 15 is row 1 / column 1.
    localparam logic [15:0][DIGIT_W-1:0] KEY_MAP = {
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic is_one_hot(input logic [LINE_W-1:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Line 1 sits on bit 3, so the index counts down from the MSB.
    function automatic logic [1:0] line_index(input logic [LINE_W-1:0] v);
        logic [1:0] idx;
        if (v[3])      idx = 2'd0;
        else if (v[2]) idx = 2'd1;
        else if (v[1]) idx = 2'd2;
        else           idx = 2'd3;
        return idx;
    endfunction

    function automatic logic [DIGIT_W-1:0] key_at(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[~{row, col}];
    endfunction

endpackage

// File: rtl/key_decoder.sv
// Combinational {rows, columns_n} key code to hex digit decode with validity flag.
module key_decoder
    import keypad_pkg::*;
(
    input  logic [CODE_W-1:0]  code,
    output logic               valid_c,
    output logic [DIGIT_W-1:0] digit_c
);

    logic [LINE_W-1:0] rows;
    logic [LINE_W-1:0] cols_hot;

    always_comb begin
        rows     = code[7:4];
        cols_hot = ~code[3:0];
        valid_c  = is_one_hot(rows) && is_one_hot(cols_hot);
        digit_c  = key_at(line_index(rows), line_index(cols_hot));
    end

endmodule

// File: rtl/keypad_digit_latch.sv
// Debounces scanner key candidates and commits one digit per press into a
// two-deep newest/previous digit history.
module keypad_digit_latch
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [CODE_W-1:0]  total_val,
    input  logic               key_pressed,
    output logic [DIGIT_W-1:0] digit_new,
    output logic [DIGIT_W-1:0] digit_old,
    output logic               new_digit,
    output logic               bad_key
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    latch_state_t       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CODE_W-1:0]  cand_q, cand_d;
    logic [DIGIT_W-1:0] digit_new_d, digit_old_d;
    logic               new_digit_d, bad_key_d;
    logic               in_valid;
    logic [DIGIT_W-1:0] in_digit;
    logic               cand_valid;
    logic [DIGIT_W-1:0] cand_digit;

    key_decoder u_in_dec (
        .code    (total_val),
        .valid_c (in_valid),
        .digit_c (in_digit)
    );

    key_decoder u_cand_dec (
        .code    (cand_q),
        .valid_c (cand_valid),
        .digit_c (cand_digit)
    );

    // Next-state, counter and digit history update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        digit_new_d = digit_new;
        digit_old_d = digit_old;
        bad_key_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    if (in_valid) begin
                        cand_d  = total_val;
                        cnt_d   = '0;
                        state_d = CHECK;
                    end else begin
                        bad_key_d = 1'b1;
                    end
                end
            end
            CHECK: begin
                // Release or a changed code aborts, even on the final count.
                if (!key_pressed || (total_val != cand_q)) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = COMMIT;
                    digit_old_d = digit_new;
                    digit_new_d = cand_digit;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            COMMIT: state_d = HOLD;
            HOLD: begin
                if (!key_pressed) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        new_digit_d = (state_d == COMMIT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cand_q    <= '0;
            digit_new <= '0;
            digit_old <= '0;
            new_digit <= 1'b0;
            bad_key   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            digit_new <= digit_new_d;
            digit_old <= digit_old_d;
            new_digit <= new_digit_d;
            bad_key   <= bad_key_d;
        end
    end

endmodule
